answer_entry: RTL

- Front-end note-entry stage that builds the answer sequence the downstream answer/playback register stores and plays on the piezo.
- Debounces eight note buttons plus enter/clear/undo buttons, encodes each press as a 4-bit note code and packs up to 8 notes into a 32-bit word.
- On enter, presents word, last-note index and a one-cycle write strobe, matching the downstream store's data_in / max_index / write_enable inputs.

---
 rtl/answer_entry.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/answer_entry.sv
// answer_entry: debounced note entry that packs up to 8 four-bit note codes
// into a 32-bit word and strobes it out to the answer store on enter.
// Optional: define ANSWER_ENTRY_UNDO_EN to enable the delete-last-note button.
module answer_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_NOTES       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  note_btn,
  input  logic        enter_btn,
  input  logic        clear_btn,
  input  logic        undo_btn,
  output logic [31:0] data_out,
  output logic [3:0]  max_index,
  output logic        write_enable,
  output logic [3:0]  note_count,
  output logic        full
);

`ifdef ANSWER_ENTRY_UNDO_EN
  localparam int unsigned VEC_W = 11;
`else
  localparam int unsigned VEC_W = 10;
`endif
  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, COMMIT} state_e;

  logic [VEC_W-1:0] raw_vec;
  logic [VEC_W-1:0] raw_q, raw_d;
  logic [VEC_W-1:0] last_q, last_d;
  logic [VEC_W-1:0] deb_q, deb_d;
  logic [VEC_W-1:0] deb_prev_q, deb_prev_d;
  logic [VEC_W-1:0] rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       max_q, max_d;
  logic             full_q, full_d;
  logic [3:0]       note_code;
  logic             notes_held;

`ifdef ANSWER_ENTRY_UNDO_EN
  logic [3:0] undo_idx;

  always_comb begin
    raw_vec  = {undo_btn, clear_btn, enter_btn, note_btn};
    undo_idx = count_q - 4'd1;
  end
`else
  logic undo_unused;

  // Undo button deliberately kept out of the debounced vector.
  always_comb begin
    raw_vec     = {clear_btn, enter_btn, note_btn};
    undo_unused = undo_btn;
  end
`endif

  // Shared debounce counter, restarted on any change of the registered vector.
  always_comb begin
    raw_d      = raw_vec;
    last_d     = raw_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    if (raw_q != last_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((raw_q == last_q) && (cnt_q == CNT_MAX)) begin
      deb_d = raw_q;
    end
  end

  always_comb begin
    rise       = deb_q & ~deb_prev_q;
    notes_held = |deb_q[7:0];
    note_code  = '0;
    // Scan high to low so the lowest asserted note bit wins.
    for (int unsigned i = 0; i < 8; i++) begin
      if (rise[7-i]) begin
        note_code = 4'(8 - i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      COMMIT: begin
        data_d  = '0;
        count_d = '0;
        state_d = notes_held ? HOLD : IDLE;
      end
      IDLE, HOLD: begin
        if ((state_q == HOLD) && !notes_held) begin
          state_d = IDLE;
        end
        if (rise[9]) begin
          data_d  = '0;
          count_d = '0;
          state_d = notes_held ? HOLD : IDLE;
        end else if (rise[8]) begin
          if (count_q != '0) begin
            state_d = COMMIT;
          end
`ifdef ANSWER_ENTRY_UNDO_EN
        end else if (rise[10]) begin
          if (count_q != '0) begin
            data_d[{undo_idx[2:0], 2'b00} +: 4] = '0;
            count_d = undo_idx;
          end
`endif
        end else if ((|rise[7:0]) && (state_q == IDLE)) begin
          if (count_q < 4'(MAX_NOTES)) begin
            data_d[{count_q[2:0], 2'b00} +: 4] = note_code;
            count_d = count_q + 4'd1;
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    max_d  = (count_d != '0) ? (count_d - 4'd1) : '0;
    full_d = (count_d == 4'(MAX_NOTES));
  end

  always_comb begin
    write_enable = (state_q == COMMIT);
    data_out     = data_q;
    max_index    = max_q;
    note_count   = count_q;
    full         = full_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= '0;
      last_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      data_q     <= '0;
      count_q    <= '0;
      max_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      raw_q      <= raw_d;
      last_q     <= last_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      data_q     <= data_d;
      count_q    <= count_d;
      max_q      <= max_d;
      full_q     <= full_d;
    end
  end

endmodule
